// File: rtl/seg_to_hex_capture.sv
// Loopback monitor for the 7-segment driver: filters the multiplexed active-low bus,
// decodes each stable digit to a nibble and hands complete 4-digit frames downstream.
module seg_to_hex_capture #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  seg,
   input  logic [3:0]  an,
   output logic [15:0] frame_hex,
   output logic [3:0]  frame_bad,
   output logic        frame_valid,
   input  logic        frame_ready,
   output logic        overrun
);

   localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

   logic [6:0]  seg_q;
   logic [3:0]  an_q;
   logic [7:0]  cnt_q,       cnt_d;
   logic [3:0]  captured_q,  captured_d;
   logic [15:0] stage_hex_q, stage_hex_d;
   logic [3:0]  stage_bad_q, stage_bad_d;
   logic [15:0] frame_hex_q, frame_hex_d;
   logic [3:0]  frame_bad_q, frame_bad_d;
   logic        frame_valid_q, frame_valid_d;
   logic        overrun_q,   overrun_d;

   logic        sample_eq;
   logic        commit;
   logic        out_free;
   logic [1:0]  digit_idx;
   logic [4:0]  dec;

   function automatic logic onehot_low(input logic [3:0] a);
      return (a == 4'b1110) || (a == 4'b1101) || (a == 4'b1011) || (a == 4'b0111);
   endfunction

   // Returns {bad, nibble}; anything outside the glyph set is flagged bad with nibble 0.
   function automatic logic [4:0] decode_glyph(input logic [6:0] s);
      case (s)
         7'h40: return 5'h00;
         7'h79: return 5'h01;
         7'h24: return 5'h02;
         7'h30: return 5'h03;
         7'h19: return 5'h04;
         7'h12: return 5'h05;
         7'h02: return 5'h06;
         7'h78: return 5'h07;
         7'h00: return 5'h08;
         7'h10: return 5'h09;
         7'h08: return 5'h0A;
         7'h03: return 5'h0B;
         7'h46: return 5'h0C;
         7'h21: return 5'h0D;
         7'h06: return 5'h0E;
         7'h0E: return 5'h0F;
         default: return 5'h10;
      endcase
   endfunction

   // The incoming sample is compared against the registered one, so the counter
   // reads 1 on the same edge that first registers a new pattern.
   assign sample_eq = ({an, seg} == {an_q, seg_q});
   assign out_free  = !frame_valid_q || frame_ready;
   assign dec       = decode_glyph(seg_q);

   always_comb begin
      digit_idx = 2'd0;
      case (an_q)
         4'b1101: digit_idx = 2'd1;
         4'b1011: digit_idx = 2'd2;
         4'b0111: digit_idx = 2'd3;
         default: digit_idx = 2'd0;
      endcase
   end

   always_comb begin
      cnt_d  = cnt_q;
      commit = 1'b0;
      if (!onehot_low(an)) begin
         cnt_d = 8'd0;
      end else if (!sample_eq) begin
         cnt_d = 8'd1;
      end else if (cnt_q < STABLE_C) begin
         cnt_d  = cnt_q + 8'd1;
         commit = (cnt_q == STABLE_C - 8'd1);
      end
   end

   always_comb begin
      captured_d    = captured_q;
      stage_hex_d   = stage_hex_q;
      stage_bad_d   = stage_bad_q;
      frame_hex_d   = frame_hex_q;
      frame_bad_d   = frame_bad_q;
      frame_valid_d = frame_valid_q;
      overrun_d     = overrun_q;

      if (frame_valid_q && frame_ready) begin
         frame_valid_d = 1'b0;
      end

      // A full staging set always empties; it either loads or is counted as dropped.
      if (captured_q == 4'hF) begin
         captured_d = 4'h0;
         if (out_free) begin
            frame_hex_d   = stage_hex_q;
            frame_bad_d   = stage_bad_q;
            frame_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end

      if (commit) begin
         stage_hex_d[{digit_idx, 2'b00} +: 4] = dec[3:0];
         stage_bad_d[digit_idx]               = dec[4];
         captured_d[digit_idx]                = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_q         <= 7'h7F;
         an_q          <= 4'hF;
         cnt_q         <= 8'd0;
         captured_q    <= 4'h0;
         stage_hex_q   <= 16'h0000;
         stage_bad_q   <= 4'h0;
         frame_hex_q   <= 16'h0000;
         frame_bad_q   <= 4'h0;
         frame_valid_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         seg_q         <= seg;
         an_q          <= an;
         cnt_q         <= cnt_d;
         captured_q    <= captured_d;
         stage_hex_q   <= stage_hex_d;
         stage_bad_q   <= stage_bad_d;
         frame_hex_q   <= frame_hex_d;
         frame_bad_q   <= frame_bad_d;
         frame_valid_q <= frame_valid_d;
         overrun_q     <= overrun_d;
      end
   end

   assign frame_hex   = frame_hex_q;
   assign frame_bad   = frame_bad_q;
   assign frame_valid = frame_valid_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_seg_to_hex_capture.sv
// Directed bench for seg_to_hex_capture: scans, glitches, bad glyphs, backpressure and
// back-to-back frame handoff with hand-computed expected frames.
module tb_seg_to_hex_capture;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic [15:0] frame_hex;
   logic [3:0]  frame_bad;
   logic        frame_valid;
   logic        frame_ready;
   logic        overrun;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          xfers    = 0;
   logic [15:0] last_hex = 16'h0;
   logic [3:0]  last_bad = 4'h0;

   seg_to_hex_capture #(.STABLE_CYCLES(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg         (seg),
      .an          (an),
      .frame_hex   (frame_hex),
      .frame_bad   (frame_bad),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   // Transfers are recorded at the falling edge, where valid/ready equal their values at the next rising edge.
   task automatic tick();
      @(negedge clk);
      if (frame_valid && frame_ready) begin
         xfers++;
         last_hex = frame_hex;
         last_bad = frame_bad;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic show(input int digit, input logic [6:0] pat, input int cycles);
      an  = ~(4'b0001 << digit);
      seg = pat;
      repeat (cycles) tick();
   endtask

   task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                       input logic [6:0] p2, input logic [6:0] p3);
      show(0, p0, 8);
      show(1, p1, 8);
      show(2, p2, 8);
      show(3, p3, 8);
   endtask

   task automatic idle(input int cycles);
      an  = 4'hF;
      seg = 7'h7F;
      repeat (cycles) tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) begin
         seg = 7'($urandom);
         an  = 4'($urandom);
         tick();
      end
      rst_n = 1'b1;
      an    = 4'hF;
      seg   = 7'h7F;
   endtask

   initial begin
      rst_n       = 1'b0;
      an          = 4'hF;
      seg         = 7'h7F;
      frame_ready = 1'b0;

      // Reset with a random bus
      do_reset();
      check("rst_hex",     32'(frame_hex),   32'h0);
      check("rst_bad",     32'(frame_bad),   32'h0);
      check("rst_valid",   32'(frame_valid), 32'h0);
      check("rst_overrun", 32'(overrun),     32'h0);

      // Clean scan; last digit held for exactly the minimum dwell
      frame_ready = 1'b1;
      idle(1);
      show(0, 7'h40, 8);
      show(1, 7'h79, 8);
      show(2, 7'h24, 8);
      show(3, 7'h30, 4);
      check("clean_valid_before", 32'(frame_valid), 32'h0);
      tick();
      check("clean_valid_rise", 32'(frame_valid), 32'h1);
      check("clean_hex",        32'(frame_hex),   32'h3210);
      check("clean_bad",        32'(frame_bad),   32'h0);
      tick();
      check("clean_xfers",      32'(xfers),       32'd1);
      check("clean_last_hex",   32'(last_hex),    32'h3210);
      check("clean_valid_drop", 32'(frame_valid), 32'h0);
      repeat (4) tick();
      check("clean_single",     32'(xfers),       32'd1);
      check("clean_overrun",    32'(overrun),     32'h0);

      // Illegal glyph on digit 2 (blank)
      idle(1);
      scan(7'h06, 7'h46, 7'h7F, 7'h21);
      check("bad_xfers",    32'(xfers),       32'd2);
      check("bad_hex",      32'(last_hex),    32'hD0CE);
      check("bad_flags",    32'(last_bad),    32'b0100);
      check("bad_valid",    32'(frame_valid), 32'h0);

      // Glitch shorter than the dwell, then digits 1..3 only: no frame may complete
      idle(1);
      show(0, 7'h19, 3);
      an = 4'b1100;
      repeat (2) tick();
      show(0, 7'h19, 3);
      idle(1);
      show(1, 7'h79, 8);
      show(2, 7'h79, 8);
      show(3, 7'h79, 8);
      check("glitch_xfers", 32'(xfers),       32'd2);
      check("glitch_valid", 32'(frame_valid), 32'h0);
      do_reset();
      check("glitch_rst_valid", 32'(frame_valid), 32'h0);

      // Backpressure: second frame dropped, first held
      frame_ready = 1'b0;
      idle(1);
      scan(7'h78, 7'h00, 7'h10, 7'h08);
      check("bp_valid1",   32'(frame_valid), 32'h1);
      check("bp_hex1",     32'(frame_hex),   32'hA987);
      check("bp_ovr1",     32'(overrun),     32'h0);
      scan(7'h03, 7'h46, 7'h21, 7'h06);
      check("bp_valid2",   32'(frame_valid), 32'h1);
      check("bp_hex2",     32'(frame_hex),   32'hA987);
      check("bp_ovr2",     32'(overrun),     32'h1);
      check("bp_no_xfer",  32'(xfers),       32'd2);
      frame_ready = 1'b1;
      tick();
      check("bp_xfers",    32'(xfers),       32'd3);
      check("bp_last_hex", 32'(last_hex),    32'hA987);
      check("bp_valid_drop", 32'(frame_valid), 32'h0);
      repeat (3) tick();
      check("bp_single",   32'(xfers),       32'd3);
      check("bp_ovr_sticky", 32'(overrun),   32'h1);
      do_reset();
      check("bp_rst_ovr",  32'(overrun),     32'h0);
      check("bp_rst_valid", 32'(frame_valid), 32'h0);

      // Back-to-back: frame 2 loads on the edge that accepts frame 1
      frame_ready = 1'b0;
      idle(1);
      scan(7'h40, 7'h79, 7'h24, 7'h30);
      check("b2b_valid1",  32'(frame_valid), 32'h1);
      show(0, 7'h12, 8);
      show(1, 7'h02, 8);
      show(2, 7'h00, 8);
      show(3, 7'h19, 4);
      check("b2b_hold_valid", 32'(frame_valid), 32'h1);
      check("b2b_hold_hex",   32'(frame_hex),   32'h3210);
      frame_ready = 1'b1;
      tick();
      check("b2b_xfers1",  32'(xfers),       32'd4);
      check("b2b_last1",   32'(last_hex),    32'h3210);
      check("b2b_valid2",  32'(frame_valid), 32'h1);
      check("b2b_hex2",    32'(frame_hex),   32'h4865);
      check("b2b_ovr",     32'(overrun),     32'h0);
      tick();
      check("b2b_xfers2",  32'(xfers),       32'd5);
      check("b2b_last2",   32'(last_hex),    32'h4865);
      check("b2b_valid_end", 32'(frame_valid), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
